dmem_arbiter: RTL

//  Shares the single-port 256x32 data memory between two requesters:

---
 rtl/dmem_arbiter_if.sv | 34 +++
 rtl/dmem_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus shared by both ports of dmem_arbiter.
// The arbiter takes the slave modport and each requester takes the master modport.
interface dmem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 32
) ();
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;
    logic          err;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  ack,
        input  rdata,
        input  err
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output ack,
        output rdata,
        output err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port 256x32 data memory; one access per three cycles.
// Optional feature macro ARB_ROUND_ROBIN_EN: round-robin tie-break instead of fixed A-first priority.
module dmem_arbiter #(
    parameter int AW    = 16,
    parameter int DW    = 32,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave a_if,
    dmem_arbiter_if.slave b_if,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          mem_write_o,
    output logic          mem_read_o,
    input  logic [DW-1:0] mem_rdata_i
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic       OWNER_A = 1'b0;
    localparam logic       OWNER_B = 1'b1;

    // One extra bit so DEPTH itself is representable even when DEPTH == 2**AW.
    localparam logic [AW:0] DEPTH_LIMIT = (AW+1)'(DEPTH);

    logic [1:0]    state_q,    state_d;
    logic          owner_q,    owner_d;
    logic          errFlag_q,  errFlag_d;
    logic [AW-1:0] memAddr_q,  memAddr_d;
    logic [DW-1:0] memWdata_q, memWdata_d;
    logic          memWrite_q, memWrite_d;
    logic          memRead_q,  memRead_d;
    logic          aAck_q,     aAck_d;
    logic          aErr_q,     aErr_d;
    logic [DW-1:0] aRdata_q,   aRdata_d;
    logic          bAck_q,     bAck_d;
    logic          bErr_q,     bErr_d;
    logic [DW-1:0] bRdata_q,   bRdata_d;

    logic          anyReq;
    logic          grantA;
    logic          grantB;
    logic          selWe;
    logic [AW-1:0] selAddr;
    logic [DW-1:0] selWdata;
    logic          selInRange;
    logic          respUpdate;
    logic [DW-1:0] respData;

    assign anyReq = a_if.req | b_if.req;

`ifdef ARB_ROUND_ROBIN_EN
    logic lastB_q;

    // On a tie the port that did not win the previous grant goes first.
    assign grantA = a_if.req & (~b_if.req | lastB_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastB_q <= 1'b1;
        end else if (state_q == IDLE && anyReq) begin
            lastB_q <= grantB;
        end
    end
`else
    assign grantA = a_if.req;
`endif

    assign grantB = b_if.req & ~grantA;

    assign selWe      = grantB ? b_if.we    : a_if.we;
    assign selAddr    = grantB ? b_if.addr  : a_if.addr;
    assign selWdata   = grantB ? b_if.wdata : a_if.wdata;
    assign selInRange = ({1'b0, selAddr} < DEPTH_LIMIT);

    // A completed in-range read loads memory data, an error clears rdata, a write leaves it alone.
    assign respUpdate = errFlag_q | memRead_q;
    assign respData   = errFlag_q ? '0 : mem_rdata_i;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        errFlag_d  = errFlag_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        memWrite_d = 1'b0;
        memRead_d  = 1'b0;
        aAck_d     = 1'b0;
        aErr_d     = 1'b0;
        aRdata_d   = aRdata_q;
        bAck_d     = 1'b0;
        bErr_d     = 1'b0;
        bRdata_d   = bRdata_q;

        case (state_q)
            IDLE: begin
                if (anyReq) begin
                    owner_d    = grantB ? OWNER_B : OWNER_A;
                    memAddr_d  = selAddr;
                    memWdata_d = selWdata;
                    memWrite_d = selWe & selInRange;
                    memRead_d  = ~selWe & selInRange;
                    errFlag_d  = ~selInRange;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (owner_q == OWNER_B) begin
                    bAck_d = 1'b1;
                    bErr_d = errFlag_q;
                    if (respUpdate) begin
                        bRdata_d = respData;
                    end
                end else begin
                    aAck_d = 1'b1;
                    aErr_d = errFlag_q;
                    if (respUpdate) begin
                        aRdata_d = respData;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Async reset also kills a pending write before the memory's negedge commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWNER_A;
            errFlag_q  <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            memWrite_q <= 1'b0;
            memRead_q  <= 1'b0;
            aAck_q     <= 1'b0;
            aErr_q     <= 1'b0;
            aRdata_q   <= '0;
            bAck_q     <= 1'b0;
            bErr_q     <= 1'b0;
            bRdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            errFlag_q  <= errFlag_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            memWrite_q <= memWrite_d;
            memRead_q  <= memRead_d;
            aAck_q     <= aAck_d;
            aErr_q     <= aErr_d;
            aRdata_q   <= aRdata_d;
            bAck_q     <= bAck_d;
            bErr_q     <= bErr_d;
            bRdata_q   <= bRdata_d;
        end
    end

    assign mem_addr_o  = memAddr_q;
    assign mem_wdata_o = memWdata_q;
    assign mem_write_o = memWrite_q;
    assign mem_read_o  = memRead_q;

    assign a_if.ack   = aAck_q;
    assign a_if.err   = aErr_q;
    assign a_if.rdata = aRdata_q;
    assign b_if.ack   = bAck_q;
    assign b_if.err   = bErr_q;
    assign b_if.rdata = bRdata_q;

endmodule
